// File: rtl/parser_in_arb.sv
// Packet-granular round-robin arbiter sharing the 32-bit parser input between
// NUM_SRC sources, with idle-timeout release and a saturating packetLost count.
module parser_in_arb #(
  parameter int NUM_SRC      = 4,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [NUM_SRC*32-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_val,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [31:0]          dataIn,
  output logic                 dataIn_val,
  output logic                 dataIN_last,
  input  logic                 dataIn_ready,
  input  logic                 packetLost,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 abort,
  output logic [CNT_W-1:0]     lost_cnt
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int TO_W  = $clog2(IDLE_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W:0]   NUM_SRC_W = (IDX_W + 1)'(NUM_SRC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [NUM_SRC-1:0] grant_r;
  logic [IDX_W-1:0]   gidx_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [TO_W-1:0]    idle_cnt_r;
  logic               abort_r;
  logic [CNT_W-1:0]   lost_cnt_r;

  logic               pick_found_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [31:0]        sel_data_s;
  logic               sel_val_s;
  logic               sel_last_s;
  logic               xfer_s;
  logic               pkt_end_s;
  logic               timeout_s;
  logic               release_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_SRC - 1)) begin
      wrap_inc = '0;
    end else begin
      wrap_inc = idx + IDX_W'(1);
    end
  endfunction

  function automatic logic [NUM_SRC-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    to_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Signals of the currently granted source
  always_comb begin
    sel_data_s = src_data[{gidx_r, 5'd0} +: 32];
    sel_val_s  = src_val[gidx_r];
    sel_last_s = src_last[gidx_r];
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping
  always_comb begin
    logic [IDX_W:0] cand;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand         = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      if (cand >= NUM_SRC_W) begin
        cand = cand - NUM_SRC_W;
      end else begin
        cand = cand;
      end
      if (!pick_found_s && src_val[cand[IDX_W-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand[IDX_W-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state logic; a release happens on last-beat transfer or idle timeout
  always_comb begin
    xfer_s    = (state_r == LOCK) && sel_val_s && dataIn_ready;
    pkt_end_s = xfer_s && sel_last_s;
    timeout_s = (state_r == LOCK) && !sel_val_s && (idle_cnt_r == TO_MAX);
    release_s = pkt_end_s || timeout_s;
    case (state_r)
      IDLE:    next_state_s = pick_found_s ? LOCK : IDLE;
      LOCK:    next_state_s = release_s ? IDLE : LOCK;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath is steered combinationally from the registered grant
  always_comb begin
    if (state_r == LOCK) begin
      dataIn      = sel_data_s;
      dataIn_val  = sel_val_s;
      dataIN_last = sel_last_s;
      src_ready   = grant_r & {NUM_SRC{dataIn_ready}};
    end else begin
      dataIn      = 32'h0000_0000;
      dataIn_val  = 1'b0;
      dataIN_last = 1'b0;
      src_ready   = '0;
    end
  end

  // State, grant, round-robin pointer and idle counter
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      gidx_r     <= '0;
      rr_ptr_r   <= '0;
      idle_cnt_r <= '0;
      abort_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      abort_r <= timeout_s;
      case (state_r)
        IDLE: begin
          idle_cnt_r <= '0;
          if (pick_found_s) begin
            gidx_r  <= pick_idx_s;
            grant_r <= to_onehot(pick_idx_s);
          end else begin
            grant_r <= '0;
          end
        end
        LOCK: begin
          if (release_s) begin
            grant_r    <= '0;
            rr_ptr_r   <= wrap_inc(gidx_r);
            idle_cnt_r <= '0;
          end else if (sel_val_s) begin
            idle_cnt_r <= '0;
          end else begin
            idle_cnt_r <= idle_cnt_r + TO_W'(1);
          end
        end
        default: begin
          grant_r    <= '0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  // Saturating packetLost event counter, independent of arbitration state
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      lost_cnt_r <= '0;
    end else if (packetLost && (lost_cnt_r != {CNT_W{1'b1}})) begin
      lost_cnt_r <= lost_cnt_r + CNT_W'(1);
    end else begin
      lost_cnt_r <= lost_cnt_r;
    end
  end

  assign grant    = grant_r;
  assign abort    = abort_r;
  assign lost_cnt = lost_cnt_r;

endmodule

// File: doc/parser_in_arb.md
Name: parser_in_arb

Overview:
- Packet-granular round-robin arbiter that shares the single 32-bit parser input stream between NUM_SRC upstream sources.
- Sits directly in front of parser. Drives its dataIn/dataIn_val/dataIN_last and honours its dataIn_ready.
- Once a source is granted, it owns the parser input until its last beat is accepted, so packets never interleave.
- Also supplies an idle-timeout release and a saturating count of parser packetLost events.

Parameters:
NUM_SRC, 4, number of upstream sources (2..8)
IDLE_TIMEOUT, 64, consecutive cycles with granted src_val low before grant is forcibly released (>=2)
CNT_W, 16, width of lost_cnt

Ports:
clk  input  1  clock; all logic on posedge
reset_b  input  1  synchronous, active-low reset
src_data  input  NUM_SRC*32  source i data at bits [32*i+31:32*i]
src_val  input  NUM_SRC  per-source beat valid
src_last  input  NUM_SRC  per-source last beat of packet
src_ready  output  NUM_SRC  per-source ready
dataIn  output  32  to parser data
dataIn_val  output  1  to parser valid
dataIN_last  output  1  to parser last
dataIn_ready  input  1  from parser ready
packetLost  input  1  from parser; one event per cycle high
grant  output  NUM_SRC  one-hot current owner; 0 when idle
abort  output  1  one-cycle pulse on timeout release
lost_cnt  output  CNT_W  saturating packetLost event count

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_b, synchronous and active-low.
- Reset behaviour: while reset_b=0 at a posedge, state=IDLE, grant=0, rr_ptr=0, idle_cnt=0, abort=0, lost_cnt=0. Reset has priority over every other event.
- Outputs in IDLE: src_ready=0, dataIn=0, dataIn_val=0, dataIN_last=0.
- Reset mid-packet: grant dropped immediately. No last is emitted. Bench must not expect packet completion.
- States: IDLE, LOCK.
- IDLE:
  - If any src_val is set, select the first requester at index >= rr_ptr, wrapping modulo NUM_SRC.
  - Register grant to that index and go to LOCK next cycle (1-cycle arbitration latency).
  - src_ready stays 0 in IDLE, so no beat is consumed during arbitration.
- LOCK, granted index g:
  - dataIn=src_data[g], dataIn_val=src_val[g], dataIN_last=src_last[g], src_ready[g]=dataIn_ready; all other src_ready=0.
  - These signals are combinational from the registered grant: zero added data latency, no buffering.
  - A beat transfers when dataIn_val && dataIn_ready.
- Packet end: on a transfer with dataIN_last=1, next cycle state=IDLE, grant=0, rr_ptr=(g+1) mod NUM_SRC. A new grant follows at the earliest one cycle later, so there is a 1-cycle bubble between packets.
- Idle timeout:
  - In LOCK, idle_cnt counts consecutive cycles with src_val[g]=0; it clears on any cycle src_val[g]=1.
  - When idle_cnt reaches IDLE_TIMEOUT-1 and src_val[g] is still 0, next cycle: state=IDLE, grant=0, rr_ptr=(g+1) mod NUM_SRC, abort=1 for exactly one cycle.
  - Backpressure from the parser (val=1, ready=0) never counts toward timeout.
- Fairness: after the current packet ends, a continuously requesting source waits at most NUM_SRC-1 other packets.
- lost_cnt:
  - Increments by 1 on each posedge with packetLost=1, saturating at all-ones.
  - Independent of state; unaffected by abort.
- Simultaneous events:
  - A last-beat transfer and the timeout cannot coincide, because a transfer requires val=1.
  - packetLost in the same cycle as a packet end is counted normally.

Test Plan:
- Reset, then src_val=0001 with a 3-beat packet 0xA0,0xA1,0xA2 (last on third), dataIn_ready=1 -> grant=0001 one cycle after src_val rises; dataIn shows A0,A1,A2 on consecutive cycles; dataIN_last on A2; grant=0 next cycle; rr_ptr=1.
- All 4 sources continuously valid with 2-beat packets -> grant sequence 0001,0010,0100,1000,0001; one idle cycle between packets; no beat interleaving; src_ready of non-granted sources always 0.
- Source 2 granted, dataIn_ready held 0 for 100 cycles with src_val[2]=1 -> no abort, grant stays 0100; raise ready -> beats drain unchanged.
- Source 1 granted, sends 1 non-last beat, then src_val[1]=0 for 64 cycles -> abort pulses 1 cycle at the 64th idle cycle boundary; grant=0; next grant goes to source 2 if requesting.
- packetLost pulsed 5 times, once during a packet-end cycle -> lost_cnt=5. With CNT_W=4 and 20 pulses -> lost_cnt=15.
- Assert reset_b=0 mid-packet (grant=1000) for 1 cycle -> next cycle grant=0, lost_cnt=0, all outputs 0; re-arbitration starts from source 0.
